dff4_skid_reg: RTL and testbench

- Registered 4-bit pipeline stage with a valid/ready handshake on both sides.
- It is the consumer-side companion to the plain 4-bit D register. A producer writes data in. A downstream stage reads it out under backpressure.
- It contains a main register and a skid register. This lets upstream ready be fully registered, so there is no combinational path from out_ready to in_ready.
- It sits between CPU pipeline stages that need stall support.

---
 rtl/dff4_skid_reg.sv | 106 ++++++++++
 tb/tb_dff4_skid_reg.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/dff4_skid_reg.sv
// dff4_skid_reg: registered WIDTH-bit pipeline stage with valid/ready on both
// sides. A main register feeds the consumer. A skid register catches the one
// word that can arrive in the cycle where the consumer stalls. Because of this,
// in_ready is decoded purely from registered state, with no path from out_ready.
module dff4_skid_reg #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       count
);

    // Occupancy state: EMPTY (no data), ONE (main full), TWO (main + skid full).
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] main_reg;
    logic [WIDTH-1:0] skid_reg;
    logic [1:0]       count_reg;
    logic             in_ready_reg;
    logic             out_valid_reg;

    logic in_fire;
    logic out_fire;

    // Handshakes use only registered flags, so neither side sees a combinational path.
    assign in_fire  = in_valid & in_ready_reg;
    assign out_fire = out_valid_reg & out_ready;

    // Occupancy FSM; data registers and decoded outputs all update together.
    always_ff @(posedge clk) begin
        if (clr || flush) begin
            // A flush looks like a reset to the datapath.
            // Any word consumed in the same cycle is simply gone.
            state_reg     <= EMPTY;
            main_reg      <= '0;
            skid_reg      <= '0;
            count_reg     <= 2'd0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
        end else begin
            unique case (state_reg)
                EMPTY: begin
                    if (in_fire) begin
                        state_reg     <= ONE;
                        main_reg      <= in_data;
                        count_reg     <= 2'd1;
                        in_ready_reg  <= 1'b1;
                        out_valid_reg <= 1'b1;
                    end
                end
                ONE: begin
                    if (in_fire && !out_fire) begin
                        // Consumer stalled: park the new word in the skid register.
                        state_reg     <= TWO;
                        skid_reg      <= in_data;
                        count_reg     <= 2'd2;
                        in_ready_reg  <= 1'b0;
                        out_valid_reg <= 1'b1;
                    end else if (!in_fire && out_fire) begin
                        state_reg     <= EMPTY;
                        count_reg     <= 2'd0;
                        in_ready_reg  <= 1'b1;
                        out_valid_reg <= 1'b0;
                    end else if (in_fire && out_fire) begin
                        // The old word leaves and the new word arrives on the same edge, with no bubble.
                        main_reg      <= in_data;
                    end
                end
                TWO: begin
                    // in_ready is low here, so only the consumer side can move.
                    if (out_fire) begin
                        state_reg     <= ONE;
                        main_reg      <= skid_reg;
                        count_reg     <= 2'd1;
                        in_ready_reg  <= 1'b1;
                        out_valid_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg     <= EMPTY;
                    count_reg     <= 2'd0;
                    in_ready_reg  <= 1'b1;
                    out_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign out_data  = main_reg;
    assign count     = count_reg;

endmodule

// File: tb/tb_dff4_skid_reg.sv
// Directed plus randomised bench for dff4_skid_reg. Every expected value comes
// either from a hand-computed constant or from a reference queue kept by the bench.
module tb_dff4_skid_reg;

    logic       clk = 1'b0;
    logic       clr;
    logic       flush;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_data;
    logic [1:0] count;

    int n_compared   = 0;
    int n_mismatched = 0;

    always #5 clk = ~clk;

    dff4_skid_reg #(.WIDTH(4)) dut (
        .clk       (clk),
        .clr       (clr),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count)
    );

    // Move past the next rising edge. Outputs are then sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_compared++;
        assert (obs === exp)
        else begin
            n_mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_count"},     {6'd0, count},     8'd0);
        check({tag, "_out_valid"}, {7'd0, out_valid}, 8'd0);
        check({tag, "_in_ready"},  {7'd0, in_ready},  8'd1);
        check({tag, "_out_data"},  {4'd0, out_data},  8'd0);
    endtask

    logic [3:0] q[$];
    logic [3:0] prev_data;
    logic       prev_stall;
    logic       exp_in_fire;
    logic       exp_out_fire;

    initial begin
        clr = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = 4'hF; out_ready = 1'b0;

        // Reset: held for two edges with a word presented, nothing accepted.
        step(); step();
        check_idle("reset");
        clr = 1'b0;
        step();
        check("rst_release_data",  {4'd0, out_data},  8'h0F);
        check("rst_release_count", {6'd0, count},     8'd1);
        check("rst_release_valid", {7'd0, out_valid}, 8'd1);

        // Streaming: one word per cycle, with count holding at 1.
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            in_data = 4'(i);
            step();
            $display("stream word %0d: out_data=%0h count=%0d in_ready=%0b", i, out_data, count, in_ready);
            check("stream_data",  {4'd0, out_data}, 8'(i));
            check("stream_count", {6'd0, count},    8'd1);
            check("stream_ready", {7'd0, in_ready}, 8'd1);
        end
        in_valid = 1'b0;
        step();
        check("stream_drain_count", {6'd0, count}, 8'd0);

        // Backpressure: A and B fill both registers, and C is held off.
        out_ready = 1'b0; in_valid = 1'b1; in_data = 4'hA;
        step();
        in_data = 4'hB;
        step();
        check("bp_full_count", {6'd0, count},    8'd2);
        check("bp_full_ready", {7'd0, in_ready}, 8'd0);
        check("bp_full_data",  {4'd0, out_data}, 8'h0A);
        in_data = 4'hC;
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp_hold_count", {6'd0, count},    8'd2);
            check("bp_hold_data",  {4'd0, out_data}, 8'h0A);
        end
        out_ready = 1'b1;
        step();
        check("bp_out_b",       {4'd0, out_data}, 8'h0B);
        check("bp_out_b_count", {6'd0, count},    8'd1);
        step();
        check("bp_out_c",       {4'd0, out_data}, 8'h0C);
        check("bp_out_c_count", {6'd0, count},    8'd1);
        in_valid = 1'b0;
        step();
        check("bp_empty_count", {6'd0, count},     8'd0);
        check("bp_empty_valid", {7'd0, out_valid}, 8'd0);

        // Simultaneous read and write while in ONE.
        out_ready = 1'b0; in_valid = 1'b1; in_data = 4'h5;
        step();
        check("rw_main5", {4'd0, out_data}, 8'h05);
        in_data = 4'h6; out_ready = 1'b1;
        step();
        check("rw_data",  {4'd0, out_data}, 8'h06);
        check("rw_count", {6'd0, count},    8'd1);
        in_valid = 1'b0;
        step();
        check("rw_drain_count", {6'd0, count}, 8'd0);

        // Flush while in TWO, with an incoming word that must be dropped.
        out_ready = 1'b0; in_valid = 1'b1; in_data = 4'h7;
        step();
        in_data = 4'h8;
        step();
        check("fl_two_count", {6'd0, count}, 8'd2);
        flush = 1'b1; in_data = 4'h9;
        step();
        check_idle("flush");
        flush = 1'b0; in_valid = 1'b0;
        step();
        check_idle("flush_after");

        // Random traffic checked against a reference queue.
        q.delete();
        prev_stall = 1'b0;
        prev_data  = 4'h0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            in_data   = 4'($urandom_range(0, 15));
            check("rnd_in_ready",  {7'd0, in_ready},  {7'd0, q.size() != 2});
            check("rnd_out_valid", {7'd0, out_valid}, {7'd0, q.size() != 0});
            exp_in_fire  = in_valid && (q.size() != 2);
            exp_out_fire = out_ready && (q.size() != 0);
            prev_stall = (q.size() != 0) && !out_ready;
            prev_data  = out_data;
            if (exp_out_fire) void'(q.pop_front());
            if (exp_in_fire) q.push_back(in_data);
            step();
            check("rnd_count", {6'd0, count}, 8'(q.size()));
            if (q.size() != 0) check("rnd_data", {4'd0, out_data}, {4'd0, q[0]});
            if (prev_stall) check("rnd_stable", {4'd0, out_data}, {4'd0, prev_data});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
